// File: rtl/overcooked_pkg.sv
// rtl/overcooked_pkg.sv - shared grid object codes, game-state codes, grid geometry and serve FSM states
package overcooked_pkg;
    localparam int GRID_W   = 13;
    localparam int GRID_H   = 8;
    localparam int SERVE_X  = 12;
    localparam int SERVE_Y0 = 4;

    localparam logic [3:0] G_EMPTY        = 4'd0;
    localparam logic [3:0] G_COUNTER      = 4'd1;
    localparam logic [3:0] G_ONION        = 4'd2;
    localparam logic [3:0] G_BOWL_EMPTY   = 4'd3;
    localparam logic [3:0] G_BOWL_FULL    = 4'd4;
    localparam logic [3:0] G_POT          = 4'd5;
    localparam logic [3:0] G_FIRE         = 4'd6;
    localparam logic [3:0] G_EXTINGUISHER = 4'd7;

    typedef enum logic [2:0] {
        GS_WELCOME = 3'd0,
        GS_START   = 3'd1,
        GS_PLAY    = 3'd2,
        GS_PAUSE   = 3'd3,
        GS_FINISH  = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2
    } serve_state_e;
endpackage

// File: rtl/order_queue.sv
// rtl/order_queue.sv - timed order queue: per-second countdown, append, serve-pop of the oldest entry, expiry compaction
module order_queue #(
    parameter int N_ORDERS   = 3,
    parameter int ORDER_TIME = 45
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     tick_i,
    input  logic                     serve_i,
    input  logic                     spawn_i,
    output logic [N_ORDERS-1:0]      valid_o,
    output logic [N_ORDERS-1:0][5:0] time_o,
    output logic [2:0]               expired_o
);
    localparam logic [5:0] FULL_TIME = 6'(ORDER_TIME);

    logic [N_ORDERS-1:0]      valid_q, valid_d, expire;
    logic [N_ORDERS-1:0][5:0] time_q, time_d;
    logic [2:0]               expired_d;
    int                       kept;

    // Survivors are packed toward index 0 in age order; a spawn lands after them.
    always_comb begin
        valid_d   = '0;
        time_d    = '0;
        expire    = '0;
        expired_d = '0;
        kept      = 0;
        for (int i = 0; i < N_ORDERS; i++) begin
            expire[i] = valid_q[i] && tick_i && (time_q[i] == 6'd0) && !(i == 0 && serve_i);
            expired_d = expired_d + {2'b00, expire[i]};
            if (valid_q[i] && !expire[i] && !(i == 0 && serve_i)) begin
                for (int j = 0; j < N_ORDERS; j++) begin
                    if (j == kept) begin
                        valid_d[j] = 1'b1;
                        time_d[j]  = tick_i ? time_q[i] - 6'd1 : time_q[i];
                    end
                end
                kept = kept + 1;
            end
        end
        if (spawn_i && kept < N_ORDERS) begin
            for (int j = 0; j < N_ORDERS; j++) begin
                if (j == kept) begin
                    valid_d[j] = 1'b1;
                    time_d[j]  = FULL_TIME;
                end
            end
        end
    end

    always_ff @(negedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
            time_q  <= '0;
        end else begin
            valid_q <= valid_d;
            time_q  <= time_d;
        end
    end

    assign valid_o   = valid_q;
    assign time_o    = time_q;
    assign expired_o = expired_d;
endmodule

// File: rtl/serving_station.sv
// rtl/serving_station.sv - serving-counter watcher: bowl serve FSMs, order matching and score; SERVE_TIP_EN adds a tip of order_time[0]>>3
module serving_station
    import overcooked_pkg::*;
#(
    parameter int N_ORDERS       = 3,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ORDER_TIME     = 45,
    parameter int SPAWN_PERIOD   = 15,
    parameter int ORDER_POINTS   = 20,
    parameter int FAIL_PENALTY   = 10
) (
    input  logic                                 vsync,
    input  logic                                 reset,
    input  logic [2:0]                           game_state,
    input  logic [GRID_H-1:0][GRID_W-1:0][3:0]   object_grid,
    output logic [1:0]                           clear_space,
    output logic [9:0]                           score,
    output logic [3:0]                           orders_failed,
    output logic [N_ORDERS-1:0]                  order_valid,
    output logic [N_ORDERS-1:0][5:0]             order_time
);
    localparam int FW = $clog2(FRAMES_PER_SEC + 1);
    localparam int SW = $clog2(SPAWN_PERIOD + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_PERIOD - 1);

    logic                     play, clr, tick, spawn, credit, first_q;
    logic [FW-1:0]            frame_q, frame_d;
    logic [SW-1:0]            spawn_q, spawn_d;
    logic [1:0]               full, go;
    serve_state_e             srv_q [2];
    serve_state_e             srv_d [2];
    logic [N_ORDERS-1:0]      q_valid;
    logic [N_ORDERS-1:0][5:0] q_time;
    logic [2:0]               expired;
    logic [11:0]              score_sum, penalty, tip;
    logic [4:0]               failed_sum;
    logic [9:0]               score_q, score_d;
    logic [3:0]               failed_q, failed_d;
    logic                     unused_grid;

    assign play  = (game_state == GS_PLAY);
    assign clr   = reset || (game_state == GS_START);
    assign tick  = play && (frame_q == FRAME_LAST);
    assign spawn = play && (first_q || (tick && spawn_q == SPAWN_LAST));

    assign full[0] = (object_grid[SERVE_Y0][SERVE_X] == G_BOWL_FULL);
    assign full[1] = (object_grid[SERVE_Y0+1][SERVE_X] == G_BOWL_FULL);
    // Cell 1 yields to cell 0 so clear_space never carries both bits.
    assign go[0]  = play && (srv_q[0] == S_IDLE) && full[0];
    assign go[1]  = play && (srv_q[1] == S_IDLE) && full[1] && !go[0];
    assign credit = (|go) && q_valid[0];
    assign unused_grid = ^object_grid;

    order_queue #(
        .N_ORDERS   (N_ORDERS),
        .ORDER_TIME (ORDER_TIME)
    ) u_queue (
        .clk_i     (vsync),
        .clr_i     (clr),
        .tick_i    (tick),
        .serve_i   (|go),
        .spawn_i   (spawn),
        .valid_o   (q_valid),
        .time_o    (q_time),
        .expired_o (expired)
    );

    always_comb begin
        frame_d = tick ? '0 : frame_q + 1'b1;
        spawn_d = spawn_q;
        if (tick) begin
            spawn_d = (spawn_q == SPAWN_LAST) ? '0 : spawn_q + 1'b1;
        end
    end

    always_comb begin
        tip = '0;
`ifdef SERVE_TIP_EN
        tip = {9'd0, q_time[0][5:3]};
`endif
        score_sum = {2'b00, score_q};
        if (credit) begin
            score_sum = score_sum + 12'(ORDER_POINTS) + tip;
        end
        if (score_sum > 12'd999) begin
            score_sum = 12'd999;
        end
        penalty    = 12'(FAIL_PENALTY) * {9'd0, expired};
        score_d    = (score_sum > penalty) ? 10'(score_sum - penalty) : '0;
        failed_sum = {1'b0, failed_q} + {2'b00, expired};
        failed_d   = (failed_sum > 5'd15) ? 4'd15 : failed_sum[3:0];
    end

    always_ff @(negedge vsync) begin
        if (clr) begin
            frame_q  <= '0;
            spawn_q  <= '0;
            first_q  <= 1'b1;
            score_q  <= '0;
            failed_q <= '0;
        end else if (play) begin
            frame_q  <= frame_d;
            spawn_q  <= spawn_d;
            first_q  <= 1'b0;
            score_q  <= score_d;
            failed_q <= failed_d;
        end
    end

    always_ff @(negedge vsync) begin
        if (clr) begin
            srv_q[0] <= S_IDLE;
            srv_q[1] <= S_IDLE;
        end else begin
            srv_q[0] <= srv_d[0];
            srv_q[1] <= srv_d[1];
        end
    end

    // WAIT holds until the bowl is gone, so a late clear never earns a second credit.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            srv_d[k] = srv_q[k];
            if (play) begin
                case (srv_q[k])
                    S_IDLE:  if (go[k]) srv_d[k] = S_CLEAR;
                    S_CLEAR: srv_d[k] = S_WAIT;
                    S_WAIT:  if (!full[k]) srv_d[k] = S_IDLE;
                    default: srv_d[k] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            clear_space[k] = play && (srv_q[k] == S_CLEAR);
        end
    end

    assign score         = score_q;
    assign orders_failed = failed_q;
    assign order_valid   = q_valid;
    assign order_time    = q_time;
endmodule

// File: tb/tb_serving_station.sv
// tb/tb_serving_station.sv - directed and randomized self-checking bench for serving_station against a queue-based reference model
module tb_serving_station;
    import overcooked_pkg::*;

    localparam int N   = 3;
    localparam int FPS = 60;
    localparam int OT  = 45;
    localparam int SP  = 15;
    localparam int PTS = 20;
    localparam int PEN = 10;
`ifdef SERVE_TIP_EN
    localparam int TIP_ON = 1;
`else
    localparam int TIP_ON = 0;
`endif

    logic                         vsync = 1'b0;
    logic                         reset;
    logic [2:0]                   game_state;
    logic [7:0][12:0][3:0]        object_grid;
    logic [1:0]                   clear_space;
    logic [9:0]                   score;
    logic [3:0]                   orders_failed;
    logic [N-1:0]                 order_valid;
    logic [N-1:0][5:0]            order_time;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses0, pulses1, both_hi;

    // reference model state
    int m_q[$];
    int m_score, m_failed, m_frame, m_spn;
    bit m_first;
    bit m_armed [2];
    int m_since [2];

    serving_station #(
        .N_ORDERS(N), .FRAMES_PER_SEC(FPS), .ORDER_TIME(OT),
        .SPAWN_PERIOD(SP), .ORDER_POINTS(PTS), .FAIL_PENALTY(PEN)
    ) dut (
        .vsync         (vsync),
        .reset         (reset),
        .game_state    (game_state),
        .object_grid   (object_grid),
        .clear_space   (clear_space),
        .score         (score),
        .orders_failed (orders_failed),
        .order_valid   (order_valid),
        .order_time    (order_time)
    );

    always #5 vsync = ~vsync;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_score  = 0;
        m_failed = 0;
        m_frame  = 0;
        m_spn    = 0;
        m_first  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_armed[k] = 1'b1;
            m_since[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [2:0] gs, input logic [3:0] c0, input logic [3:0] c1, input logic rst);
        bit full [2];
        bit go [2];
        bit tick, spawn, credit;
        int tip, exp_n, s;
        int nq[$];
        if (rst || gs == GS_START) begin
            model_clear();
            return;
        end
        if (gs != GS_PLAY) return;
        tick    = (m_frame == FPS - 1);
        m_frame = tick ? 0 : m_frame + 1;
        full[0] = (c0 == G_BOWL_FULL);
        full[1] = (c1 == G_BOWL_FULL);
        go[0]   = m_armed[0] && full[0];
        go[1]   = m_armed[1] && full[1] && !go[0];
        for (int k = 0; k < 2; k++) begin
            if (!m_armed[k]) begin
                if (m_since[k] >= 1 && !full[k]) m_armed[k] = 1'b1;
                m_since[k]++;
            end
            if (go[k]) begin
                m_armed[k] = 1'b0;
                m_since[k] = 0;
            end
        end
        credit = 1'b0;
        tip    = 0;
        if ((go[0] || go[1]) && m_q.size() > 0) begin
            credit = 1'b1;
            tip    = TIP_ON ? m_q[0] / 8 : 0;
            void'(m_q.pop_front());
        end
        exp_n = 0;
        if (tick) begin
            foreach (m_q[i]) begin
                if (m_q[i] == 0) exp_n++;
                else nq.push_back(m_q[i] - 1);
            end
            m_q = nq;
        end
        s = m_score + (credit ? PTS + tip : 0);
        if (s > 999) s = 999;
        s = s - PEN * exp_n;
        m_score  = (s < 0) ? 0 : s;
        m_failed = (m_failed + exp_n > 15) ? 15 : m_failed + exp_n;
        spawn = m_first || (tick && m_spn == SP - 1);
        if (tick) m_spn = (m_spn == SP - 1) ? 0 : m_spn + 1;
        m_first = 1'b0;
        if (spawn && m_q.size() < N) m_q.push_back(OT);
    endtask

    task automatic check_frame();
        logic [1:0]   exp_clr;
        logic [N-1:0] ev;
        exp_clr = 2'b00;
        if (game_state == GS_PLAY) begin
            for (int k = 0; k < 2; k++) exp_clr[k] = !m_armed[k] && (m_since[k] == 0);
        end
        ev = '0;
        for (int i = 0; i < m_q.size(); i++) ev[i] = 1'b1;
        cmp("clear_space", clear_space, exp_clr);
        cmp("score", score, m_score);
        cmp("orders_failed", orders_failed, m_failed);
        cmp("order_valid", order_valid, ev);
        for (int i = 0; i < m_q.size(); i++) cmp("order_time", order_time[i], m_q[i]);
    endtask

    task automatic step(input logic [2:0] gs, input logic [3:0] c0, input logic [3:0] c1, input logic rst);
        reset             = rst;
        game_state        = gs;
        object_grid[4][12] = c0;
        object_grid[5][12] = c1;
        #1;
        check_frame();
        if (clear_space[0] === 1'b1) pulses0++;
        if (clear_space[1] === 1'b1) pulses1++;
        if (clear_space === 2'b11) both_hi++;
        @(negedge vsync);
        model_edge(gs, c0, c1, rst);
        @(posedge vsync);
    endtask

    task automatic run(input logic [2:0] gs, input int n);
        repeat (n) step(gs, G_EMPTY, G_EMPTY, 1'b0);
    endtask

    task automatic clr_pulses();
        pulses0 = 0;
        pulses1 = 0;
        both_hi = 0;
    endtask

    initial begin
        logic [2:0] rgs;
        logic [3:0] rc0, rc1;
        logic       rrst;
        int         r;

        object_grid = '0;
        reset       = 1'b1;
        game_state  = GS_WELCOME;
        repeat (2) @(negedge vsync);
        @(posedge vsync);
        model_clear();
        #1;
        cmp("reset_clear_space", clear_space, 0);
        cmp("reset_score", score, 0);
        cmp("reset_failed", orders_failed, 0);
        cmp("reset_valid", order_valid, 0);

        // first PLAY frame spawns one order
        step(GS_START, G_EMPTY, G_EMPTY, 1'b0);
        step(GS_PLAY, G_EMPTY, G_EMPTY, 1'b0);
        cmp("first_valid", order_valid, 3'b001);
        cmp("first_time0", order_time[0], 45);
        cmp("first_score", score, 0);

        // one bowl held for three frames earns a single credit
        clr_pulses();
        repeat (3) step(GS_PLAY, G_BOWL_FULL, G_EMPTY, 1'b0);
        repeat (2) step(GS_PLAY, G_EMPTY, G_EMPTY, 1'b0);
        cmp("serve_pulses", pulses0, 1);
        cmp("serve_score", score, 20 + TIP_ON * 5);
        cmp("serve_valid", order_valid, 3'b000);

        // both cells full together with two orders pending
        step(GS_START, G_EMPTY, G_EMPTY, 1'b0);
        run(GS_PLAY, 900);
        cmp("two_orders_valid", order_valid, 3'b011);
        clr_pulses();
        repeat (4) step(GS_PLAY, G_BOWL_FULL, G_BOWL_FULL, 1'b0);
        repeat (2) step(GS_PLAY, G_EMPTY, G_EMPTY, 1'b0);
        cmp("dual_pulses0", pulses0, 1);
        cmp("dual_pulses1", pulses1, 1);
        cmp("dual_never_both", both_hi, 0);
        cmp("dual_score", score, 40 + TIP_ON * 8);

        // 46 seconds without serving: oldest order expires
        step(GS_START, G_EMPTY, G_EMPTY, 1'b0);
        run(GS_PLAY, 2760);
        cmp("expire_failed", orders_failed, 1);
        cmp("expire_score", score, 0);
        cmp("expire_valid", order_valid, 3'b011);
        cmp("expire_time0", order_time[0], 14);
        cmp("expire_time1", order_time[1], 29);

        // pause freezes timers and withholds the clear
        clr_pulses();
        repeat (120) step(GS_PAUSE, G_BOWL_FULL, G_EMPTY, 1'b0);
        cmp("pause_time0", order_time[0], 14);
        cmp("pause_time1", order_time[1], 29);
        cmp("pause_pulses", pulses0, 0);
        repeat (3) step(GS_PLAY, G_BOWL_FULL, G_EMPTY, 1'b0);
        step(GS_PLAY, G_EMPTY, G_EMPTY, 1'b0);
        cmp("resume_pulses", pulses0, 1);
        cmp("resume_score", score, 20 + TIP_ON * 1);
        cmp("resume_valid", order_valid, 3'b001);
        cmp("resume_time0", order_time[0], 29);

        // reset during the clear frame drops clear_space on that edge
        step(GS_PLAY, G_BOWL_FULL, G_EMPTY, 1'b0);
        step(GS_PLAY, G_BOWL_FULL, G_EMPTY, 1'b1);
        #1;
        cmp("reset_mid_clear", clear_space, 0);
        cmp("reset_mid_score", score, 0);
        step(GS_WELCOME, G_EMPTY, G_EMPTY, 1'b0);

        // serve with 40 s left on the oldest order
        step(GS_START, G_EMPTY, G_EMPTY, 1'b0);
        run(GS_PLAY, 300);
        cmp("tip_time0", order_time[0], 40);
        step(GS_PLAY, G_BOWL_FULL, G_EMPTY, 1'b0);
        run(GS_PLAY, 2);
        cmp("tip_score", score, 20 + TIP_ON * 5);

        // randomized traffic against the model
        rc0 = G_EMPTY;
        rc1 = G_EMPTY;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      rgs = GS_PLAY;
            else if (r < 88) rgs = GS_PAUSE;
            else if (r < 94) rgs = GS_WELCOME;
            else             rgs = GS_FINISH;
            if ($urandom_range(0, 499) == 0) rgs = GS_START;
            if ($urandom_range(0, 3) == 0)
                rc0 = ($urandom_range(0, 1) == 1) ? G_BOWL_FULL : 4'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                rc1 = ($urandom_range(0, 1) == 1) ? G_BOWL_FULL : 4'($urandom_range(0, 7));
            rrst = ($urandom_range(0, 999) == 0);
            step(rgs, rc0, rc1, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
